// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache controller: default widths,
// controller state encoding and the saturating-increment helper.
package icache_pkg;

    localparam int unsigned ADDR_WIDTH_DEF  = 32;
    localparam int unsigned DATA_WIDTH_DEF  = 32;
    localparam int unsigned INDEX_WIDTH_DEF = 5;
    localparam int unsigned CTR_WIDTH       = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        FLUSH
    } state_e;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [CTR_WIDTH-1:0] sat_inc(input logic [CTR_WIDTH-1:0] value);
        return (&value) ? value : value + CTR_WIDTH'(1);
    endfunction

endpackage

// File: rtl/icache_if.sv
// Bus bundle between the cache controller and its neighbours: CPU fetch port,
// flush control, refill memory port and tag/data storage port.
// The master modport is the controller's view; slave is the environment's.
interface icache_if
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;

    // CPU fetch port
    logic                   cpu_req_valid;
    logic                   cpu_req_ready;
    logic [ADDR_WIDTH-1:0]  cpu_req_addr;
    logic                   cpu_resp_valid;
    logic [DATA_WIDTH-1:0]  cpu_resp_data;

    // Flush control
    logic                   flush_req;
    logic                   flush_done;

    // Refill port towards memory
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [ADDR_WIDTH-1:0]  mem_req_addr;
    logic                   mem_resp_valid;
    logic [DATA_WIDTH-1:0]  mem_resp_data;

    // Tag/data storage port
    logic                   st_compare_en;
    logic [ADDR_WIDTH-1:0]  st_addr;
    logic                   st_hit;
    logic [DATA_WIDTH-1:0]  st_rdata;
    logic                   st_wr_en;
    logic [ADDR_WIDTH-1:0]  st_wr_addr;
    logic [DATA_WIDTH-1:0]  st_wr_data;
    logic [TAG_WIDTH-1:0]   st_wr_tag;
    logic                   st_wr_valid;

    modport master (
        input  cpu_req_valid, cpu_req_addr,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_data,
        input  flush_req,
        output flush_done,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output st_compare_en, st_addr,
        input  st_hit, st_rdata,
        output st_wr_en, st_wr_addr, st_wr_data, st_wr_tag, st_wr_valid
    );

    modport slave (
        output cpu_req_valid, cpu_req_addr,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_data,
        output flush_req,
        input  flush_done,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  st_compare_en, st_addr,
        output st_hit, st_rdata,
        input  st_wr_en, st_wr_addr, st_wr_data, st_wr_tag, st_wr_valid
    );

endinterface

// File: rtl/icache_perf_ctr.sv
// 32-bit saturating event counter used for the hit and miss statistics.
module icache_perf_ctr
    import icache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 inc,
    output logic [CTR_WIDTH-1:0] count
);

    logic [CTR_WIDTH-1:0] cnt_q;

    // Count one event per cycle when inc is high, holding at the maximum.
    // NOTE: clocked state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/icache_ctrl.sv
// Instruction-cache controller: accepts CPU fetches, probes the external
// tag/data storage, refills misses from memory and sweeps the whole index
// space to invalidate it on request. A flush requested while a miss is in
// flight is remembered and started once the refill has been delivered.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
)(
    input  logic                 clk,
    input  logic                 reset_n,
    icache_if.master             bus,
    output logic [CTR_WIDTH-1:0] hit_count,
    output logic [CTR_WIDTH-1:0] miss_count
);

    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [INDEX_WIDTH-1:0]  flush_idx_q, flush_idx_d;
    logic                    flush_pending_q, flush_pending_d;
    logic                    hit_inc;
    logic                    miss_inc;
    logic                    flush_seen;

    // A flush is due either from the live request or from one noted mid-miss.
    assign flush_seen = bus.flush_req || flush_pending_q;

    // State, latched request address, sweep index and deferred-flush flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            req_addr_q      <= '0;
            flush_idx_q     <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_addr_q      <= req_addr_d;
            flush_idx_q     <= flush_idx_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // Next-state decode and all bus outputs for the current state.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d         = state_q;
        req_addr_d      = req_addr_q;
        flush_idx_d     = flush_idx_q;
        flush_pending_d = flush_pending_q;
        hit_inc         = 1'b0;
        miss_inc        = 1'b0;

        bus.cpu_req_ready  = 1'b0;
        bus.cpu_resp_valid = 1'b0;
        bus.cpu_resp_data  = DATA_WIDTH'(0);
        bus.flush_done     = 1'b0;
        bus.mem_req_valid  = 1'b0;
        bus.mem_req_addr   = ADDR_WIDTH'(0);
        bus.st_compare_en  = 1'b0;
        bus.st_addr        = ADDR_WIDTH'(0);
        bus.st_wr_en       = 1'b0;
        bus.st_wr_addr     = ADDR_WIDTH'(0);
        bus.st_wr_data     = DATA_WIDTH'(0);
        bus.st_wr_tag      = TAG_WIDTH'(0);
        bus.st_wr_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush_seen) begin
                    // Flush wins over a fetch; the CPU sees ready low.
                    state_d     = FLUSH;
                    flush_idx_d = '0;
                end else begin
                    // Ready is masked while reset is held so it reads 0.
                    bus.cpu_req_ready = reset_n;
                    if (bus.cpu_req_valid) begin
                        req_addr_d = bus.cpu_req_addr;
                        state_d    = LOOKUP;
                    end
                end
            end

            LOOKUP: begin
                bus.st_compare_en = 1'b1;
                bus.st_addr       = req_addr_q;
                if (bus.flush_req) flush_pending_d = 1'b1;
                if (bus.st_hit) begin
                    bus.cpu_resp_valid = 1'b1;
                    bus.cpu_resp_data  = bus.st_rdata;
                    hit_inc            = 1'b1;
                    state_d            = IDLE;
                end else begin
                    miss_inc = 1'b1;
                    state_d  = MEM_REQ;
                end
            end

            MEM_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = req_addr_q;
                if (bus.flush_req) flush_pending_d = 1'b1;
                if (bus.mem_req_ready) state_d = MEM_WAIT;
            end

            MEM_WAIT: begin
                if (bus.flush_req) flush_pending_d = 1'b1;
                if (bus.mem_resp_valid) begin
                    // Fill the line and forward the word in the same cycle.
                    bus.st_wr_en       = 1'b1;
                    bus.st_wr_addr     = req_addr_q;
                    bus.st_wr_data     = bus.mem_resp_data;
                    bus.st_wr_tag      = req_addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
                    bus.st_wr_valid    = 1'b1;
                    bus.cpu_resp_valid = 1'b1;
                    bus.cpu_resp_data  = bus.mem_resp_data;
                    state_d            = IDLE;
                end
            end

            FLUSH: begin
                // One invalidating write per index; flush_req is not looked at
                // here so a held request cannot stretch the sweep.
                bus.st_wr_en   = 1'b1;
                bus.st_wr_addr = ADDR_WIDTH'(flush_idx_q);
                flush_idx_d    = flush_idx_q + INDEX_WIDTH'(1);
                if (&flush_idx_q) begin
                    bus.flush_done  = 1'b1;
                    flush_pending_d = 1'b0;
                    state_d         = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    icache_perf_ctr hit_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (hit_inc),
        .count   (hit_count)
    );

    icache_perf_ctr miss_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (miss_inc),
        .count   (miss_count)
    );

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed testbench for icache_ctrl. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_icache_ctrl;
    import icache_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_cmp;
    int n_err;

    icache_if bus ();

    icache_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.cpu_req_valid  = 1'b0;
        bus.cpu_req_addr   = '0;
        bus.flush_req      = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.st_hit         = 1'b0;
        bus.st_rdata       = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clk); #1;
        n_cmp++; if (bus.cpu_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", bus.cpu_req_ready); end
        n_cmp++; if (bus.st_wr_en !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.cpu_resp_valid !== 1'b0 || bus.flush_done !== 1'b0 || bus.st_compare_en !== 1'b0)
            begin n_err++; $display("FAIL rst_ctrl: wr_en=%b mreq=%b resp=%b done=%b cmp=%b want all 0", bus.st_wr_en, bus.mem_req_valid, bus.cpu_resp_valid, bus.flush_done, bus.st_compare_en); end
        n_cmp++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin n_err++; $display("FAIL rst_ctr: hit=%h miss=%h want 0/0", hit_count, miss_count); end
        @(negedge clk); reset_n = 1'b1; #1;
        n_cmp++; if (bus.cpu_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", bus.cpu_req_ready); end
    endtask

    task automatic test_cold_miss();
        @(negedge clk); bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = 32'h0000_0043; #1;
        n_cmp++; if (bus.cpu_req_ready !== 1'b1) begin n_err++; $display("FAIL miss_accept: ready=%b want 1", bus.cpu_req_ready); end
        @(negedge clk); bus.cpu_req_valid = 1'b0; bus.cpu_req_addr = '0; #1;
        n_cmp++; if (bus.st_compare_en !== 1'b1 || bus.st_addr !== 32'h43) begin n_err++; $display("FAIL miss_lookup: cmp=%b addr=%h want 1/43", bus.st_compare_en, bus.st_addr); end
        @(negedge clk); bus.mem_req_ready = 1'b1; #1;
        n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h43) begin n_err++; $display("FAIL miss_memreq: valid=%b addr=%h want 1/43", bus.mem_req_valid, bus.mem_req_addr); end
        n_cmp++; if (miss_count !== 32'd1) begin n_err++; $display("FAIL miss_count: got %0d want 1", miss_count); end
        @(negedge clk); bus.mem_req_ready = 1'b0; #1;
        n_cmp++; if (bus.st_wr_en !== 1'b0 || bus.cpu_resp_valid !== 1'b0) begin n_err++; $display("FAIL miss_wait1: wr_en=%b resp=%b want 0/0", bus.st_wr_en, bus.cpu_resp_valid); end
        @(negedge clk); #1;
        n_cmp++; if (bus.mem_req_valid !== 1'b0 || bus.cpu_resp_valid !== 1'b0) begin n_err++; $display("FAIL miss_wait2: mreq=%b resp=%b want 0/0", bus.mem_req_valid, bus.cpu_resp_valid); end
        @(negedge clk); bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hDEAD_BEEF; #1;
        n_cmp++; if (bus.st_wr_en !== 1'b1 || bus.st_wr_valid !== 1'b1) begin n_err++; $display("FAIL refill_we: wr_en=%b wr_valid=%b want 1/1", bus.st_wr_en, bus.st_wr_valid); end
        n_cmp++; if (bus.st_wr_addr[4:0] !== 5'd3 || bus.st_wr_tag !== 27'h2) begin n_err++; $display("FAIL refill_idx_tag: idx=%0d tag=%h want 3/2", bus.st_wr_addr[4:0], bus.st_wr_tag); end
        n_cmp++; if (bus.st_wr_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL refill_data: got %h want deadbeef", bus.st_wr_data); end
        n_cmp++; if (bus.cpu_resp_valid !== 1'b1 || bus.cpu_resp_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL refill_resp: valid=%b data=%h want 1/deadbeef", bus.cpu_resp_valid, bus.cpu_resp_data); end
        @(negedge clk); bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0; #1;
        n_cmp++; if (bus.cpu_req_ready !== 1'b1 || bus.cpu_resp_valid !== 1'b0) begin n_err++; $display("FAIL miss_back_idle: ready=%b resp=%b want 1/0", bus.cpu_req_ready, bus.cpu_resp_valid); end
    endtask

    // One hit transaction; leaves the bench 1 ns after the falling edge in IDLE.
    task automatic do_hit(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk); bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = addr; #1;
        n_cmp++; if (bus.cpu_req_ready !== 1'b1) begin n_err++; $display("FAIL hit_accept: ready=%b want 1", bus.cpu_req_ready); end
        @(negedge clk); bus.cpu_req_valid = 1'b0; bus.st_hit = 1'b1; bus.st_rdata = data; #1;
        n_cmp++; if (bus.cpu_resp_valid !== 1'b1 || bus.cpu_resp_data !== data) begin n_err++; $display("FAIL hit_resp: valid=%b data=%h want 1/%h", bus.cpu_resp_valid, bus.cpu_resp_data, data); end
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL hit_no_memreq: got %b want 0", bus.mem_req_valid); end
        @(negedge clk); bus.st_hit = 1'b0; bus.st_rdata = '0; #1;
        n_cmp++; if (bus.cpu_resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.cpu_req_ready !== 1'b1)
            begin n_err++; $display("FAIL hit_after: resp=%b mreq=%b ready=%b want 0/0/1", bus.cpu_resp_valid, bus.mem_req_valid, bus.cpu_req_ready); end
    endtask

    task automatic test_hit();
        do_hit(32'h0000_0043, 32'hDEAD_BEEF);
        n_cmp++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin n_err++; $display("FAIL hit_count: hit=%0d miss=%0d want 1/1", hit_count, miss_count); end
    endtask

    // Checks 32 sweep cycles starting at the current falling edge.
    task automatic check_sweep(input string name);
        for (int i = 0; i < 32; i++) begin
            #1;
            n_cmp++;
            if (bus.st_wr_en !== 1'b1 || bus.st_wr_addr !== 32'(i) || bus.st_wr_valid !== 1'b0 ||
                bus.st_wr_data !== 32'h0 || bus.st_wr_tag !== 27'h0 || bus.cpu_req_ready !== 1'b0 || bus.st_compare_en !== 1'b0) begin
                n_err++;
                $display("FAIL %s_write%0d: wr_en=%b addr=%h wr_valid=%b data=%h tag=%h ready=%b cmp=%b want 1/%h/0/0/0/0/0",
                         name, i, bus.st_wr_en, bus.st_wr_addr, bus.st_wr_valid, bus.st_wr_data, bus.st_wr_tag,
                         bus.cpu_req_ready, bus.st_compare_en, i);
            end
            n_cmp++;
            if (bus.flush_done !== (i == 31)) begin
                n_err++; $display("FAIL %s_done%0d: got %b want %b", name, i, bus.flush_done, (i == 31));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush_idle();
        @(negedge clk); bus.flush_req = 1'b1; bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = 32'h43; #1;
        n_cmp++; if (bus.cpu_req_ready !== 1'b0) begin n_err++; $display("FAIL flush_prio_ready: got %b want 0", bus.cpu_req_ready); end
        @(negedge clk); bus.flush_req = 1'b0; bus.cpu_req_valid = 1'b0; bus.cpu_req_addr = '0;
        check_sweep("flush_idle");
        #1;
        n_cmp++; if (bus.st_wr_en !== 1'b0 || bus.flush_done !== 1'b0 || bus.cpu_req_ready !== 1'b1 || bus.st_compare_en !== 1'b0)
            begin n_err++; $display("FAIL flush_idle_end: wr_en=%b done=%b ready=%b cmp=%b want 0/0/1/0", bus.st_wr_en, bus.flush_done, bus.cpu_req_ready, bus.st_compare_en); end
    endtask

    task automatic test_flush_in_miss();
        @(negedge clk); bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = 32'h0000_0025;
        @(negedge clk); bus.cpu_req_valid = 1'b0; bus.cpu_req_addr = '0;
        @(negedge clk); bus.mem_req_ready = 1'b1;
        @(negedge clk); bus.mem_req_ready = 1'b0; bus.flush_req = 1'b1; #1;
        n_cmp++; if (bus.cpu_req_ready !== 1'b0 || bus.st_wr_en !== 1'b0) begin n_err++; $display("FAIL fmiss_wait: ready=%b wr_en=%b want 0/0", bus.cpu_req_ready, bus.st_wr_en); end
        @(negedge clk); bus.flush_req = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h1234_5678; #1;
        n_cmp++; if (bus.st_wr_en !== 1'b1 || bus.st_wr_valid !== 1'b1 || bus.st_wr_addr !== 32'h25 || bus.st_wr_tag !== 27'h1)
            begin n_err++; $display("FAIL fmiss_refill: wr_en=%b wr_valid=%b addr=%h tag=%h want 1/1/25/1", bus.st_wr_en, bus.st_wr_valid, bus.st_wr_addr, bus.st_wr_tag); end
        n_cmp++; if (bus.cpu_resp_valid !== 1'b1 || bus.cpu_resp_data !== 32'h1234_5678 || bus.flush_done !== 1'b0)
            begin n_err++; $display("FAIL fmiss_resp: valid=%b data=%h done=%b want 1/12345678/0", bus.cpu_resp_valid, bus.cpu_resp_data, bus.flush_done); end
        @(negedge clk); bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0; #1;
        n_cmp++; if (bus.cpu_req_ready !== 1'b0 || bus.st_wr_en !== 1'b0) begin n_err++; $display("FAIL fmiss_idle: ready=%b wr_en=%b want 0/0", bus.cpu_req_ready, bus.st_wr_en); end
        @(negedge clk);
        check_sweep("flush_miss");
        #1;
        n_cmp++; if (bus.cpu_req_ready !== 1'b1 || miss_count !== 32'd2) begin n_err++; $display("FAIL fmiss_end: ready=%b miss=%0d want 1/2", bus.cpu_req_ready, miss_count); end
    endtask

    task automatic test_flush_held();
        @(negedge clk); bus.flush_req = 1'b1;
        @(negedge clk);
        check_sweep("flush_held");
        #1;
        n_cmp++; if (bus.cpu_req_ready !== 1'b0 || bus.st_wr_en !== 1'b0) begin n_err++; $display("FAIL held_gap: ready=%b wr_en=%b want 0/0", bus.cpu_req_ready, bus.st_wr_en); end
        @(negedge clk); bus.flush_req = 1'b0;
        check_sweep("flush_again");
        #1;
        n_cmp++; if (bus.cpu_req_ready !== 1'b1 || bus.st_wr_en !== 1'b0) begin n_err++; $display("FAIL held_end: ready=%b wr_en=%b want 1/0", bus.cpu_req_ready, bus.st_wr_en); end
    endtask

    task automatic test_stall_and_reset();
        @(negedge clk); bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = 32'h0000_007F;
        @(negedge clk); bus.cpu_req_valid = 1'b0; bus.cpu_req_addr = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h7F) begin
                n_err++; $display("FAIL stall%0d: valid=%b addr=%h want 1/7f", i, bus.mem_req_valid, bus.mem_req_addr);
            end
        end
        @(negedge clk); bus.mem_req_ready = 1'b1; #1;
        n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h7F) begin n_err++; $display("FAIL stall_release: valid=%b addr=%h want 1/7f", bus.mem_req_valid, bus.mem_req_addr); end
        @(negedge clk); bus.mem_req_ready = 1'b0; #1;
        n_cmp++; if (bus.mem_req_valid !== 1'b0 || bus.st_wr_en !== 1'b0) begin n_err++; $display("FAIL stall_wait: mreq=%b wr_en=%b want 0/0", bus.mem_req_valid, bus.st_wr_en); end
        #2; reset_n = 1'b0; #1;
        n_cmp++; if (bus.cpu_req_ready !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd0)
            begin n_err++; $display("FAIL midmiss_rst: ready=%b hit=%0d miss=%0d want 0/0/0", bus.cpu_req_ready, hit_count, miss_count); end
        @(negedge clk); reset_n = 1'b1; #1;
        n_cmp++; if (bus.cpu_req_ready !== 1'b1) begin n_err++; $display("FAIL midmiss_release: ready=%b want 1", bus.cpu_req_ready); end
        @(negedge clk); bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hAAAA_5555; #1;
        n_cmp++; if (bus.st_wr_en !== 1'b0 || bus.cpu_resp_valid !== 1'b0) begin n_err++; $display("FAIL stale_resp: wr_en=%b resp=%b want 0/0", bus.st_wr_en, bus.cpu_resp_valid); end
        @(negedge clk); bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0; #1;
        n_cmp++; if (bus.cpu_req_ready !== 1'b1 || miss_count !== 32'd0) begin n_err++; $display("FAIL stale_after: ready=%b miss=%0d want 1/0", bus.cpu_req_ready, miss_count); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.hit_ctr.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.hit_ctr.cnt_q;
        do_hit(32'h0000_0043, 32'hDEAD_BEEF);
        n_cmp++; if (hit_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_first: got %h want ffffffff", hit_count); end
        do_hit(32'h0000_0043, 32'hDEAD_BEEF);
        n_cmp++; if (hit_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffffffff", hit_count); end
        n_cmp++; if (miss_count !== 32'd0) begin n_err++; $display("FAIL sat_miss: got %0d want 0", miss_count); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_flush_idle();
        test_flush_in_miss();
        test_flush_held();
        test_stall_and_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-free word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter INDEX_WIDTH, default 5, cache index width; TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports cpu_req_valid in 1, cpu_req_ready out 1, cpu_req_addr in ADDR_WIDTH: CPU fetch request handshake.
REQ-007 SHALL have ports cpu_resp_valid out 1, cpu_resp_data out DATA_WIDTH: one-cycle fetch response, no backpressure.
REQ-008 SHALL have ports flush_req in 1 (level, sampled), flush_done out 1 (one-cycle pulse).
REQ-009 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_req_addr out ADDR_WIDTH: refill request to memory.
REQ-010 SHALL have ports mem_resp_valid in 1, mem_resp_data in DATA_WIDTH: refill data, arbitrary latency.
REQ-011 SHALL have storage-side ports st_compare_en out 1, st_addr out ADDR_WIDTH, st_hit in 1, st_rdata in DATA_WIDTH.
REQ-012 SHALL have storage write ports st_wr_en out 1, st_wr_addr out ADDR_WIDTH, st_wr_data out DATA_WIDTH, st_wr_tag out TAG_WIDTH, st_wr_valid out 1.
REQ-013 SHALL have ports hit_count out 32, miss_count out 32: performance counters.

Function
REQ-014 SHALL implement FSM states IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FLUSH.
REQ-015 IDLE: cpu_req_ready=1 only when no flush is pending; on cpu_req_valid&&ready, latch addr into req_addr, go LOOKUP.
REQ-016 IDLE: pending flush (flush_req high, or flush_pending set) takes priority over cpu_req; cpu_req_ready=0 that cycle; go FLUSH with index counter=0.
REQ-017 LOOKUP: st_compare_en=1, st_addr=req_addr; if st_hit, cpu_resp_valid=1, cpu_resp_data=st_rdata, hit_count+1, go IDLE (hit latency 1 cycle after acceptance).
REQ-018 LOOKUP miss: miss_count+1, go MEM_REQ.
REQ-019 MEM_REQ: mem_req_valid=1, mem_req_addr=req_addr held stable until mem_req_ready; on handshake go MEM_WAIT.
REQ-020 MEM_WAIT: on mem_resp_valid, same cycle st_wr_en=1, st_wr_addr=req_addr, st_wr_data=mem_resp_data, st_wr_tag=req_addr[ADDR_WIDTH-1:INDEX_WIDTH], st_wr_valid=1, cpu_resp_valid=1, cpu_resp_data=mem_resp_data; go IDLE.
REQ-021 mem_resp_valid outside MEM_WAIT SHALL be ignored.
REQ-022 FLUSH: each cycle st_wr_en=1, st_wr_addr index field=counter, st_wr_valid=0, st_wr_data=0, st_wr_tag=0; counter+1.
REQ-023 FLUSH: on counter=2^INDEX_WIDTH-1 write, flush_done=1 that cycle, counter wraps to 0, clear flush_pending, go IDLE; flush takes exactly 2^INDEX_WIDTH cycles.
REQ-024 flush_req asserted in LOOKUP/MEM_REQ/MEM_WAIT SHALL set flush_pending; the in-flight miss completes (including its refill write) before FLUSH starts.
REQ-025 flush_req held high during FLUSH SHALL not extend or restart the current sweep; if still high in the following IDLE, a new sweep starts.
REQ-026 Counters SHALL saturate at 32'hFFFF_FFFF, never wrap.
REQ-027 Outside states listed, st_compare_en, st_wr_en, mem_req_valid, cpu_resp_valid, flush_done SHALL be 0.

Reset
REQ-028 reset_n low SHALL immediately force state IDLE, counters 0, flush_pending 0, flush index 0, req_addr 0.
REQ-029 During reset all outputs SHALL be 0 except cpu_req_ready, which is 0 while reset_n low and 1 in first IDLE cycle after release.
REQ-030 Reset mid-miss SHALL abandon the refill; a later stale mem_resp_valid is ignored per REQ-021.

Structure
REQ-031 State encoding enum and default widths SHALL live in shared package icache_pkg.
REQ-032 One sub-module icache_perf_ctr (32-bit saturating incrementer) SHALL be instantiated twice.

Verification
REQ-033 Cold miss: req addr 0x0000_0043, mem_req_ready=1, resp after 3 cycles data 0xDEAD_BEEF -> miss_count=1, write index 3 tag 0x2, cpu_resp_data=0xDEAD_BEEF.
REQ-034 Re-request 0x0000_0043 with st_hit=1, st_rdata=0xDEAD_BEEF -> cpu_resp_valid one cycle after accept, hit_count=1, no mem_req_valid.
REQ-035 flush_req pulse in IDLE -> 32 consecutive st_wr_en cycles, indices 0..31, st_wr_valid=0, flush_done on 32nd cycle only.
REQ-036 flush_req during MEM_WAIT -> refill write and response occur first, then FLUSH begins next IDLE cycle, cpu_req_ready=0 throughout.
REQ-037 mem_req_ready low 5 cycles -> mem_req_addr stable, no state advance; reset_n low in MEM_WAIT -> IDLE, counters 0, later mem_resp_valid causes no write.
REQ-038 Counter preloaded to 0xFFFF_FFFE via force, two hits -> hit_count holds 0xFFFF_FFFF.
